// File: rtl/mips_inst_driver_if.sv
// Handshake bundle between the instruction driver, the processor under test
// and the result checker.
interface mips_inst_driver_if;
  logic        start;
  logic        OpDone;
  logic [31:0] inst;
  logic        pcEn;
  logic        busy;
  logic        done;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;

  modport master (
    input  start,
    input  OpDone,
    output inst,
    output pcEn,
    output busy,
    output done,
    output pass_cnt,
    output fail_cnt
  );

  modport slave (
    output start,
    output OpDone,
    input  inst,
    input  pcEn,
    input  busy,
    input  done,
    input  pass_cnt,
    input  fail_cnt
  );
endinterface

// File: rtl/mips_inst_driver.sv
// Pseudo-random MIPS ALU instruction transmitter: issues one instruction per
// pcEn strobe, waits for the checker's OpDone, and tallies passes/timeouts.
package AluCtrlSig_pkg;
  localparam logic [5:0] ADD_op  = 6'b000000;
  localparam logic [5:0] ADDI_op = 6'b001000;
  localparam logic [5:0] AND_fn  = 6'd0;
  localparam logic [5:0] OR_fn   = 6'd1;
  localparam logic [5:0] ADD_fn  = 6'd2;
  localparam logic [5:0] SUB_fn  = 6'd6;
  localparam logic [5:0] SLT_fn  = 6'd7;
  localparam logic [5:0] NOR_fn  = 6'd12;
  localparam logic [5:0] XOR_fn  = 6'd13;
endpackage

module mips_inst_driver #(
  parameter int          NUM_INST = 16,
  parameter int          TIMEOUT  = 8,
  parameter int          GAP      = 2,
  parameter logic [31:0] SEED     = 32'hACE1_2345
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_inst_driver_if.master    bus
);
  import AluCtrlSig_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] SEED_EFF   = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
  localparam logic [31:0] NUM_INST_U = 32'(NUM_INST);
  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);
  localparam logic [31:0] GAP_M1     = 32'(GAP - 1);
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

  state_t      state_r;
  logic [31:0] lfsr_r;
  logic [31:0] issue_cnt_r;
  logic [31:0] wait_cnt_r;
  logic [31:0] gap_cnt_r;
  logic [31:0] inst_r;
  logic        pc_en_r;
  logic        busy_r;
  logic        done_r;
  logic [15:0] pass_cnt_r;
  logic [15:0] fail_cnt_r;

  logic        run_req_s;
  logic        gap_end_s;
  logic        launch_s;

  // Galois right-shift step; a non-zero state never maps to zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    logic [31:0] nxt;
    nxt = {1'b0, l[31:1]};
    if (l[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  function automatic logic [5:0] funct_sel(input logic [2:0] idx);
    logic [5:0] fn;
    case (idx)
      3'd0:    fn = ADD_fn;
      3'd1:    fn = SUB_fn;
      3'd2:    fn = AND_fn;
      3'd3:    fn = OR_fn;
      3'd4:    fn = NOR_fn;
      3'd5:    fn = SLT_fn;
      3'd6:    fn = XOR_fn;
      default: fn = ADD_fn;
    endcase
    return fn;
  endfunction

  // rd of zero would make the result unobservable, so it is forced to r1.
  function automatic logic [31:0] build_inst(input logic [25:0] l);
    logic [4:0]  rd;
    logic [31:0] word;
    rd = (l[15:11] == 5'd0) ? 5'd1 : l[15:11];
    if (l[2:0] == 3'd7) begin
      word = {ADDI_op, l[25:21], l[20:16], l[15:0]};
    end else begin
      word = {ADD_op, l[25:21], l[20:16], rd, 5'd0, funct_sel(l[5:3])};
    end
    return word;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'h0001);
  endfunction

  // Decode when the next edge launches a new instruction.
  always_comb begin
    run_req_s = bus.start && ((state_r == S_IDLE) || (state_r == S_DONE));
    gap_end_s = (state_r == S_GAP) && (gap_cnt_r == GAP_M1);
    launch_s  = (run_req_s && (NUM_INST_U != 32'd0)) ||
                (gap_end_s && (issue_cnt_r < NUM_INST_U));
  end

  // Run-control state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      lfsr_r      <= SEED_EFF;
      issue_cnt_r <= 32'd0;
      wait_cnt_r  <= 32'd0;
      gap_cnt_r   <= 32'd0;
      inst_r      <= 32'd0;
      pc_en_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_cnt_r  <= 16'd0;
      fail_cnt_r  <= 16'd0;
    end else begin
      pc_en_r <= 1'b0;
      if (run_req_s) begin
        pass_cnt_r <= 16'd0;
        fail_cnt_r <= 16'd0;
      end
      if (launch_s) begin
        state_r     <= S_ISSUE;
        pc_en_r     <= 1'b1;
        inst_r      <= build_inst(lfsr_r[25:0]);
        lfsr_r      <= lfsr_step(lfsr_r);
        issue_cnt_r <= (run_req_s ? 32'd0 : issue_cnt_r) + 32'd1;
        busy_r      <= 1'b1;
        done_r      <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE, S_DONE: begin
            if (run_req_s) begin
              state_r     <= S_DONE;
              issue_cnt_r <= 32'd0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end
          end
          S_ISSUE: begin
            state_r    <= S_WAIT;
            wait_cnt_r <= 32'd0;
          end
          S_WAIT: begin
            // A pass in the last WAIT cycle takes priority over the timeout.
            if (bus.OpDone) begin
              pass_cnt_r <= sat_inc(pass_cnt_r);
              state_r    <= S_GAP;
              gap_cnt_r  <= 32'd0;
            end else if (wait_cnt_r == TIMEOUT_M1) begin
              fail_cnt_r <= sat_inc(fail_cnt_r);
              state_r    <= S_GAP;
              gap_cnt_r  <= 32'd0;
            end else begin
              wait_cnt_r <= wait_cnt_r + 32'd1;
            end
          end
          S_GAP: begin
            if (gap_end_s) begin
              state_r <= S_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              gap_cnt_r <= gap_cnt_r + 32'd1;
            end
          end
          default: begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.inst     = inst_r;
  assign bus.pcEn     = pc_en_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pass_cnt = pass_cnt_r;
  assign bus.fail_cnt = fail_cnt_r;

endmodule

// File: doc/mips_inst_driver.md
# mips_inst_driver

Stimulus transmitter that generates pseudo-random MIPS ALU instructions, presents each one to the processor and to the result checker as a one-cycle `pcEn` strobe, then waits for the checker's `OpDone` pulse. It counts passes and timeouts, and sits in the Veloce testbench between the stimulus controller (`start`/`done`) and the DUT plus checker pair.

## Interface
- `NUM_INST`, 16: instructions issued per run; 0 means a run completes with no issues.
- `TIMEOUT`, 8: maximum WAIT cycles allowed for `OpDone` (≥1).
- `GAP`, 2: idle cycles after each result, letting the checker finish its cycle sequence (≥1).
- `SEED`, 32'hACE1_2345: LFSR load value; 0 is replaced by 32'h0000_0001.
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle run request; honoured only in IDLE or DONE
- `OpDone`  in  1  checker pass pulse
- `inst`  out  32  instruction word; valid while `pcEn`=1
- `pcEn`  out  1  instruction strobe, exactly one cycle per instruction
- `busy`  out  1  high in ISSUE, WAIT and GAP
- `done`  out  1  high in DONE
- `pass_cnt`  out  16  instructions that received `OpDone`
- `fail_cnt`  out  16  instructions that timed out

## Operation
- Opcode and funct constants come from `AluCtrlSig_pkg` (`ADD_op`, `ADDI_op`).
- Funct table: ADD=2, SUB=6, AND=0, OR=1, NOR=12, SLT=7, XOR=13.
- `inst` is built from the current LFSR value `L`, before the LFSR advances:
  - Type: `L[2:0]==7` gives ADDI: {ADDI_op, rs=L[25:21], rt=L[20:16], imm=L[15:0]}.
  - Otherwise R-type: {ADD_op, rs=L[25:21], rt=L[20:16], rd, shamt=5'd0, funct}.
  - rd = L[15:11]; if that is 0, rd = 1.
  - funct index L[5:3]: 0→ADD, 1→SUB, 2→AND, 3→OR, 4→NOR, 5→SLT, 6→XOR, 7→ADD.
- LFSR: 32-bit Galois, right shift, taps mask 32'h8020_0003 XORed in when the shifted-out bit is 1. It advances once per ISSUE cycle and is never all-zero.
- States:
  - IDLE: `start`=1 clears the counters and `issue_cnt`, then goes to ISSUE. If `NUM_INST`=0 it goes to DONE instead.
  - ISSUE: 1 cycle. `pcEn`=1, `inst` driven, `issue_cnt`++. Then WAIT.
  - WAIT: `wait_cnt` counts 0..TIMEOUT-1.
    - `OpDone`=1 → `pass_cnt`++, then GAP.
    - Otherwise, at `wait_cnt`==TIMEOUT-1 → `fail_cnt`++, then GAP.
    - `OpDone` in the final WAIT cycle counts as a pass, not a fail.
  - GAP: lasts `GAP` cycles. Then ISSUE if `issue_cnt`<NUM_INST, else DONE.
  - DONE: `done` held at 1. `start` restarts the run: counters clear, LFSR is NOT reloaded, next state is ISSUE.
- `start` during ISSUE, WAIT or GAP is ignored.
- `OpDone` outside WAIT is ignored, including a late pulse arriving in GAP.
- `pass_cnt` and `fail_cnt` saturate at 16'hFFFF.
- `inst` holds its last value when `pcEn`=0.

## Timing
- Reset values: `inst`=0, `pcEn`=0, `busy`=0, `done`=0, `pass_cnt`=0, `fail_cnt`=0, state IDLE, LFSR=SEED.
- Reset asserted mid-run returns every output to its reset value immediately (asynchronously), with no completion of the pending instruction.
- `start` sampled at edge E → `pcEn`=1 in the cycle after E.
- A nominal checker returns `OpDone` in the 3rd WAIT cycle.
- Per-instruction period: 1 (ISSUE) + k (WAIT, k≤TIMEOUT) + GAP cycles.
- Counter updates are visible the cycle after the deciding WAIT cycle.
- `done` rises the cycle after the last GAP cycle.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 → all outputs 0, `pcEn` never asserts.
- First instruction, SEED=32'hACE1_2345, pulse `start` → `inst`={ADD_op, rs=7, rt=1, rd=4, shamt=0, funct=2}, `pcEn` high exactly 1 cycle.
- Pass path, NUM_INST=1, model returns `OpDone` in WAIT cycle 3 → `pass_cnt`=1, `fail_cnt`=0, `done`=1 exactly 6 cycles after `pcEn`.
- Timeout, `OpDone` tied 0, NUM_INST=4 → `fail_cnt`=4, `pass_cnt`=0; each period is 1+8+2=11 cycles. A late `OpDone` injected in GAP is not counted.
- Boundary: `OpDone` in WAIT cycle 8 → pass. `start` while busy → ignored. NUM_INST=0 → `done`=1 the cycle after `start`, no `pcEn`.
- Reset mid-WAIT, then restart → counters 0, first `inst` again decoded from SEED.
